// File: rtl/memory_access_stage.sv
// memory_access_stage
//   Memory stage of the five-stage pipeline. Issues RISC-V loads and stores
//   on a valid/ready data-memory bus, formats store byte lanes, extracts and
//   extends load data, stalls upstream while an access is outstanding, and
//   registers the writeback-side results.
//
// Ports
//   clock, reset                 rising-edge clock, synchronous active-high reset
//   address, storeData, func3    effective address, rs2 value, size/signedness
//   memoryReadEnable/WriteEnable load / store request from execute
//   writeBackFromMemoryOrAlu     1 = result is load data, 0 = ALU result
//   pcAdder                      PC+4 passthrough
//   memRequest*                  bus request channel (valid/ready)
//   memResponseValid/Data        bus read-response channel
//   stall                        freezes upstream pipeline registers and PC
//   writeBackDataOut, writeBackFromMemoryOrAluOut, pcAdderOut
//                                registered results toward writeback
//   accessFault                  one-cycle pulse on illegal access or timeout
module memory_access_stage #(
    parameter int unsigned MAX_WAIT_CYCLES = 15
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] address,
    input  logic [31:0] storeData,
    input  logic [2:0]  func3,
    input  logic        memoryReadEnable,
    input  logic        memoryWriteEnable,
    input  logic        writeBackFromMemoryOrAlu,
    input  logic [31:0] pcAdder,
    output logic        memRequestValid,
    input  logic        memRequestReady,
    output logic        memRequestWrite,
    output logic [31:0] memRequestAddress,
    output logic [31:0] memRequestWriteData,
    output logic [3:0]  memRequestByteEnable,
    input  logic        memResponseValid,
    input  logic [31:0] memResponseData,
    output logic        stall,
    output logic [31:0] writeBackDataOut,
    output logic        writeBackFromMemoryOrAluOut,
    output logic [31:0] pcAdderOut,
    output logic        accessFault
);

    localparam int unsigned CW = $clog2(MAX_WAIT_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, REQUEST, WAIT_RESPONSE, DONE} state_t;

    state_t        state, stateNext;
    logic [CW-1:0] waitCount;
    logic [2:0]    func3Q;
    logic [1:0]    offsetQ;
    logic [31:0]   loadData;

    logic          accessRequested, accessLegal, accessIllegal;
    logic          funcLegal, alignLegal;
    logic [31:0]   laneData;
    logic [3:0]    laneEnable;
    logic [7:0]    loadByte;
    logic [15:0]   loadHalf;
    logic [31:0]   extracted;
    logic          handshake, responseTaken, timeout, abort;

    // Access legality, decoded from the execute-stage inputs.
    always_comb begin
        accessRequested = memoryReadEnable | memoryWriteEnable;
        if (memoryWriteEnable)
            funcLegal = func3 inside {3'b000, 3'b001, 3'b010};
        else
            funcLegal = func3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        case (func3[1:0])
            2'b01:   alignLegal = ~address[0];
            2'b10:   alignLegal = (address[1:0] == 2'b00);
            default: alignLegal = 1'b1;
        endcase
        accessLegal   = accessRequested && !(memoryReadEnable && memoryWriteEnable)
                        && funcLegal && alignLegal;
        accessIllegal = accessRequested && !accessLegal;
    end

    // Store lane replication and byte enables.
    always_comb begin
        case (func3)
            3'b000: begin
                laneData   = {4{storeData[7:0]}};
                laneEnable = 4'b0001 << address[1:0];
            end
            3'b001: begin
                laneData   = {2{storeData[15:0]}};
                laneEnable = 4'b0011 << address[1:0];
            end
            default: begin
                laneData   = storeData;
                laneEnable = 4'b1111;
            end
        endcase
    end

    // Load extraction uses the func3/offset captured at issue, not the live inputs.
    always_comb begin
        case (offsetQ)
            2'd0:    loadByte = memResponseData[7:0];
            2'd1:    loadByte = memResponseData[15:8];
            2'd2:    loadByte = memResponseData[23:16];
            default: loadByte = memResponseData[31:24];
        endcase
        loadHalf = offsetQ[1] ? memResponseData[31:16] : memResponseData[15:0];
        case (func3Q)
            3'b000:  extracted = {{24{loadByte[7]}}, loadByte};
            3'b100:  extracted = {24'h0, loadByte};
            3'b001:  extracted = {{16{loadHalf[15]}}, loadHalf};
            3'b101:  extracted = {16'h0, loadHalf};
            default: extracted = memResponseData;
        endcase
    end

    always_comb begin
        handshake     = (state == REQUEST) && memRequestReady;
        responseTaken = (state == WAIT_RESPONSE) && memResponseValid;
        // >= rather than == so a load accepted on the final cycle still times out in WAIT_RESPONSE.
        timeout       = ((state == REQUEST) || (state == WAIT_RESPONSE))
                        && (waitCount >= CW'(MAX_WAIT_CYCLES - 1));
        abort         = timeout && !handshake && !responseTaken;
        memRequestValid = (state == REQUEST);

        stateNext = state;
        stall     = 1'b0;
        case (state)
            IDLE: begin
                stall = accessLegal;
                if (accessLegal)
                    stateNext = REQUEST;
            end
            REQUEST: begin
                stall = 1'b1;
                if (handshake)
                    stateNext = memRequestWrite ? DONE : WAIT_RESPONSE;
                else if (timeout)
                    stateNext = DONE;
            end
            WAIT_RESPONSE: begin
                stall = 1'b1;
                if (responseTaken || timeout)
                    stateNext = DONE;
            end
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state                       <= IDLE;
            waitCount                   <= '0;
            func3Q                      <= '0;
            offsetQ                     <= '0;
            loadData                    <= '0;
            memRequestWrite             <= 1'b0;
            memRequestAddress           <= '0;
            memRequestWriteData         <= '0;
            memRequestByteEnable        <= '0;
            writeBackDataOut            <= '0;
            writeBackFromMemoryOrAluOut <= 1'b0;
            pcAdderOut                  <= '0;
            accessFault                 <= 1'b0;
        end else begin
            state <= stateNext;

            if (state == IDLE)
                waitCount <= '0;
            else if (stall && (waitCount != CW'(MAX_WAIT_CYCLES)))
                waitCount <= waitCount + 1'b1;

            if (state == IDLE && accessLegal) begin
                memRequestAddress    <= {address[31:2], 2'b00};
                memRequestWrite      <= memoryWriteEnable;
                memRequestWriteData  <= memoryWriteEnable ? laneData : '0;
                memRequestByteEnable <= memoryWriteEnable ? laneEnable : 4'b0000;
                func3Q               <= func3;
                offsetQ              <= address[1:0];
                // Cleared at issue so a timed-out load leaves a zero result.
                loadData             <= '0;
            end else if (responseTaken) begin
                loadData <= extracted;
            end

            accessFault <= ((state == IDLE) && accessIllegal) || abort;

            if (!stall) begin
                if (state == IDLE && accessIllegal)
                    writeBackDataOut <= '0;
                else if (state == DONE && memoryReadEnable && writeBackFromMemoryOrAlu)
                    writeBackDataOut <= loadData;
                else
                    writeBackDataOut <= address;
                writeBackFromMemoryOrAluOut <= writeBackFromMemoryOrAlu;
                pcAdderOut                  <= pcAdder;
            end
        end
    end

endmodule

// File: tb/tb_memory_access_stage.sv
module tb_memory_access_stage;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] address, storeData, pcAdder;
    logic [2:0]  func3;
    logic        memoryReadEnable, memoryWriteEnable, writeBackFromMemoryOrAlu;
    logic        memRequestValid, memRequestReady, memRequestWrite;
    logic [31:0] memRequestAddress, memRequestWriteData;
    logic [3:0]  memRequestByteEnable;
    logic        memResponseValid;
    logic [31:0] memResponseData;
    logic        stall;
    logic [31:0] writeBackDataOut;
    logic        writeBackFromMemoryOrAluOut;
    logic [31:0] pcAdderOut;
    logic        accessFault;

    int unsigned checkCount = 0;
    int unsigned passCount  = 0;

    always #5 clock = ~clock;

    memory_access_stage #(.MAX_WAIT_CYCLES(15)) dut (
        .clock(clock),
        .reset(reset),
        .address(address),
        .storeData(storeData),
        .func3(func3),
        .memoryReadEnable(memoryReadEnable),
        .memoryWriteEnable(memoryWriteEnable),
        .writeBackFromMemoryOrAlu(writeBackFromMemoryOrAlu),
        .pcAdder(pcAdder),
        .memRequestValid(memRequestValid),
        .memRequestReady(memRequestReady),
        .memRequestWrite(memRequestWrite),
        .memRequestAddress(memRequestAddress),
        .memRequestWriteData(memRequestWriteData),
        .memRequestByteEnable(memRequestByteEnable),
        .memResponseValid(memResponseValid),
        .memResponseData(memResponseData),
        .stall(stall),
        .writeBackDataOut(writeBackDataOut),
        .writeBackFromMemoryOrAluOut(writeBackFromMemoryOrAluOut),
        .pcAdderOut(pcAdderOut),
        .accessFault(accessFault)
    );

    task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual === expected)
            passCount++;
        else
            $display("FAIL %s: got %h expected %h", tag, actual, expected);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic aluOp(input logic [31:0] addr, input logic wb);
        address = addr; storeData = '0; func3 = 3'b000; pcAdder = addr + 32'd4;
        memoryReadEnable = 1'b0; memoryWriteEnable = 1'b0; writeBackFromMemoryOrAlu = wb;
        memRequestReady = 1'b0; memResponseValid = 1'b0; memResponseData = '0;
    endtask

    task automatic doStore(input string tag, input logic [31:0] addr, input logic [2:0] f3,
                           input logic [31:0] sd, input logic [31:0] expData,
                           input logic [3:0] expBe, input int unsigned waits);
        int unsigned cyc = 0;
        int unsigned waited = 0;
        address = addr; storeData = sd; func3 = f3; pcAdder = addr + 32'd4;
        memoryReadEnable = 1'b0; memoryWriteEnable = 1'b1; writeBackFromMemoryOrAlu = 1'b0;
        memRequestReady = 1'b0;
        #1;
        while (stall && cyc < 40) begin
            if (memRequestValid) begin
                if (waited == 0) begin
                    check({tag, " addr"}, memRequestAddress, {addr[31:2], 2'b00});
                    check({tag, " wdata"}, memRequestWriteData, expData);
                    check({tag, " be"}, {28'h0, memRequestByteEnable}, {28'h0, expBe});
                    check({tag, " write"}, {31'h0, memRequestWrite}, 32'h1);
                end
                memRequestReady = (waited >= waits);
                waited++;
            end
            tick();
            cyc++;
        end
        memRequestReady = 1'b0;
        check({tag, " stall cycles"}, cyc, 2 + waits);
        check({tag, " done valid"}, {31'h0, memRequestValid}, 32'h0);
        tick();
        check({tag, " result"}, writeBackDataOut, addr);
        check({tag, " pc"}, pcAdderOut, addr + 32'd4);
        aluOp(32'h0, 1'b0);
    endtask

    // Junk response is presented in IDLE and alongside ready in REQUEST; only the
    // response seen in WAIT_RESPONSE may be used.
    task automatic doLoad(input string tag, input logic [31:0] addr, input logic [2:0] f3,
                          input logic [31:0] resp, input logic [31:0] expected);
        address = addr; storeData = '0; func3 = f3; pcAdder = addr + 32'd4;
        memoryReadEnable = 1'b1; memoryWriteEnable = 1'b0; writeBackFromMemoryOrAlu = 1'b1;
        memRequestReady = 1'b1; memResponseValid = 1'b1; memResponseData = 32'hDEADBEEF;
        #1;
        check({tag, " stall idle"}, {31'h0, stall}, 32'h1);
        tick();
        check({tag, " valid"}, {31'h0, memRequestValid}, 32'h1);
        check({tag, " addr"}, memRequestAddress, {addr[31:2], 2'b00});
        check({tag, " be"}, {28'h0, memRequestByteEnable}, 32'h0);
        tick();
        check({tag, " stall wait"}, {31'h0, stall}, 32'h1);
        memRequestReady = 1'b0; memResponseValid = 1'b1; memResponseData = resp;
        tick();
        memResponseValid = 1'b0;
        check({tag, " stall done"}, {31'h0, stall}, 32'h0);
        tick();
        check({tag, " result"}, writeBackDataOut, expected);
        check({tag, " wbsel"}, {31'h0, writeBackFromMemoryOrAluOut}, 32'h1);
        aluOp(32'h0, 1'b0);
    endtask

    initial begin
        reset = 1'b1;
        aluOp(32'h0, 1'b0);
        tick();
        tick();
        reset = 1'b0;
        check("reset valid", {31'h0, memRequestValid}, 32'h0);
        check("reset write", {31'h0, memRequestWrite}, 32'h0);
        check("reset addr", memRequestAddress, 32'h0);
        check("reset wdata", memRequestWriteData, 32'h0);
        check("reset be", {28'h0, memRequestByteEnable}, 32'h0);
        check("reset stall", {31'h0, stall}, 32'h0);
        check("reset wbdata", writeBackDataOut, 32'h0);
        check("reset wbsel", {31'h0, writeBackFromMemoryOrAluOut}, 32'h0);
        check("reset pc", pcAdderOut, 32'h0);
        check("reset fault", {31'h0, accessFault}, 32'h0);

        // Non-memory instruction: one cycle through the stage.
        aluOp(32'h1234, 1'b0);
        #1;
        check("alu stall", {31'h0, stall}, 32'h0);
        check("alu valid", {31'h0, memRequestValid}, 32'h0);
        tick();
        check("alu result", writeBackDataOut, 32'h1234);
        check("alu pc", pcAdderOut, 32'h1238);

        doStore("SB", 32'h103, 3'b000, 32'h000000AB, 32'hABABABAB, 4'b1000, 0);
        doStore("SH", 32'h102, 3'b001, 32'h1234ABCD, 32'hABCDABCD, 4'b1100, 0);
        doStore("SW", 32'h100, 3'b010, 32'hCAFEF00D, 32'hCAFEF00D, 4'b1111, 2);

        doLoad("LB",  32'h102, 3'b000, 32'h00800000, 32'hFFFFFF80);
        doLoad("LBU", 32'h102, 3'b100, 32'h00800000, 32'h00000080);
        doLoad("LH",  32'h102, 3'b001, 32'h80010000, 32'hFFFF8001);
        doLoad("LHU", 32'h100, 3'b101, 32'h0000F00F, 32'h0000F00F);
        doLoad("LW",  32'h104, 3'b010, 32'h13579BDF, 32'h13579BDF);

        // Misaligned word load.
        aluOp(32'h2, 1'b1);
        func3 = 3'b010; memoryReadEnable = 1'b1;
        #1;
        check("misaligned stall", {31'h0, stall}, 32'h0);
        check("misaligned valid", {31'h0, memRequestValid}, 32'h0);
        tick();
        check("misaligned fault", {31'h0, accessFault}, 32'h1);
        check("misaligned result", writeBackDataOut, 32'h0);
        check("misaligned valid after", {31'h0, memRequestValid}, 32'h0);
        aluOp(32'h55, 1'b0);
        tick();
        check("misaligned fault clears", {31'h0, accessFault}, 32'h0);
        check("after fault result", writeBackDataOut, 32'h55);

        // Both enables set is illegal.
        aluOp(32'h100, 1'b0);
        memoryReadEnable = 1'b1; memoryWriteEnable = 1'b1;
        #1;
        check("both-enable stall", {31'h0, stall}, 32'h0);
        tick();
        check("both-enable fault", {31'h0, accessFault}, 32'h1);
        aluOp(32'h0, 1'b0);
        tick();

        // Timeout with ready held low: 15 cycles in REQUEST, then DONE with a fault.
        aluOp(32'h200, 1'b1);
        func3 = 3'b010; memoryReadEnable = 1'b1;
        #1;
        check("timeout stall idle", {31'h0, stall}, 32'h1);
        tick();
        for (int i = 0; i < 15; i++) begin
            check("timeout valid held", {31'h0, memRequestValid}, 32'h1);
            tick();
        end
        check("timeout valid dropped", {31'h0, memRequestValid}, 32'h0);
        check("timeout fault", {31'h0, accessFault}, 32'h1);
        check("timeout stall done", {31'h0, stall}, 32'h0);
        tick();
        check("timeout result", writeBackDataOut, 32'h0);
        check("timeout fault clears", {31'h0, accessFault}, 32'h0);
        aluOp(32'h66, 1'b0);
        tick();
        check("resume result", writeBackDataOut, 32'h66);

        // Reset while waiting for a response; a later response must be ignored.
        aluOp(32'h300, 1'b1);
        func3 = 3'b010; memoryReadEnable = 1'b1; memRequestReady = 1'b1;
        tick();
        memRequestReady = 1'b0;
        tick();
        check("rst-wait stall", {31'h0, stall}, 32'h1);
        reset = 1'b1;
        aluOp(32'h0, 1'b0);
        tick();
        reset = 1'b0;
        check("rst-wait valid", {31'h0, memRequestValid}, 32'h0);
        check("rst-wait stall after", {31'h0, stall}, 32'h0);
        check("rst-wait addr", memRequestAddress, 32'h0);
        check("rst-wait wbdata", writeBackDataOut, 32'h0);
        check("rst-wait pc", pcAdderOut, 32'h0);
        aluOp(32'h77, 1'b1);
        memResponseValid = 1'b1; memResponseData = 32'hFFFFFFFF;
        #1;
        check("late response stall", {31'h0, stall}, 32'h0);
        tick();
        memResponseValid = 1'b0;
        check("late response ignored", writeBackDataOut, 32'h77);
        check("late response valid", {31'h0, memRequestValid}, 32'h0);
        check("late response fault", {31'h0, accessFault}, 32'h0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
